// File: rtl/lfsr_test_sequencer.sv
// lfsr_test_sequencer
//
// Runs a write-then-read-back memory test. Two external 8-bit LFSRs provide
// the data: the write-pattern LFSR supplies the write data, and the
// check-pattern LFSR supplies the value each read return is compared
// against. Both are loaded with the same seed, so they produce the same
// sequence. Each one advances only when its data is consumed.
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; LFSRs disabled, no memory traffic
// LOAD   | one cycle: load the latched seed into both LFSRs
// WRITE  | write gen_data to words 0..last_addr, one word per mem_ack
// READ   | issue reads 0..last_addr and check each return in order
// FINISH | one cycle: done pulse, pass valid
//
// Ports
//   clk, reset_n                   clock, async active-low reset
//   start, seed_in, last_addr      run request and its configuration
//   gen_* / chk_*                  control of, and data from, the two LFSRs
//   mem_wr_req, mem_rd_req,
//   mem_addr, mem_wdata, mem_ack   memory request / handshake
//   mem_rvalid, mem_rdata          in-order read return
//   busy, done, pass,
//   err_count, first_err_addr      status

module lfsr_test_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        seed_in,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              gen_enable,
    output logic              gen_pause,
    output logic              gen_load,
    output logic [7:0]        gen_ldata,
    input  logic [7:0]        gen_data,
    output logic              chk_enable,
    output logic              chk_pause,
    output logic              chk_load,
    output logic [7:0]        chk_ldata,
    input  logic [7:0]        chk_data,
    output logic              mem_wr_req,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_READ,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        seed_q, seed_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    // Set once the read of last_addr has been accepted. A separate flag is
    // needed because rd_addr wraps to 0 when last_addr is all-ones.
    logic              rd_done_q, rd_done_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [ADDR_W-1:0] first_err_q, first_err_d;
    logic              pass_q, pass_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            seed_q      <= 8'd0;
            last_q      <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            ret_addr_q  <= '0;
            rd_done_q   <= 1'b0;
            err_count_q <= 8'd0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            last_q      <= last_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            ret_addr_q  <= ret_addr_d;
            rd_done_q   <= rd_done_d;
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        last_d      = last_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        ret_addr_d  = ret_addr_q;
        rd_done_d   = rd_done_q;
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;

        gen_enable  = 1'b0;
        gen_pause   = 1'b0;
        gen_load    = 1'b0;
        gen_ldata   = 8'd0;
        chk_enable  = 1'b0;
        chk_pause   = 1'b0;
        chk_load    = 1'b0;
        chk_ldata   = 8'd0;
        mem_wr_req  = 1'b0;
        mem_rd_req  = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 8'd0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    seed_d      = seed_in;
                    last_d      = last_addr;
                    err_count_d = 8'd0;
                    first_err_d = '0;
                    pass_d      = 1'b0;
                end
            end

            S_LOAD: begin
                busy       = 1'b1;
                gen_enable = 1'b1;
                chk_enable = 1'b1;
                gen_pause  = 1'b1;
                chk_pause  = 1'b1;
                gen_load   = 1'b1;
                chk_load   = 1'b1;
                gen_ldata  = seed_q;
                chk_ldata  = seed_q;
                wr_addr_d  = '0;
                state_d    = S_WRITE;
            end

            S_WRITE: begin
                busy       = 1'b1;
                gen_enable = 1'b1;
                chk_enable = 1'b1;
                // The pattern only advances once the current word is accepted,
                // so a stalled write keeps presenting the same data.
                gen_pause  = !mem_ack;
                chk_pause  = 1'b1;
                mem_wr_req = 1'b1;
                mem_addr   = wr_addr_q;
                mem_wdata  = gen_data;
                if (mem_ack) begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    if (wr_addr_q == last_q) begin
                        state_d    = S_READ;
                        rd_addr_d  = '0;
                        ret_addr_d = '0;
                        rd_done_d  = 1'b0;
                    end
                end
            end

            S_READ: begin
                busy       = 1'b1;
                gen_enable = 1'b1;
                chk_enable = 1'b1;
                gen_pause  = 1'b1;
                chk_pause  = !mem_rvalid;
                mem_rd_req = !rd_done_q;
                mem_addr   = rd_addr_q;
                if (!rd_done_q && mem_ack) begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (rd_addr_q == last_q) begin
                        rd_done_d = 1'b1;
                    end
                end
                if (mem_rvalid) begin
                    ret_addr_d = ret_addr_q + ADDR_W'(1);
                    if (mem_rdata != chk_data) begin
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        // The count saturates and never returns to zero, so a
                        // zero count identifies the first mismatch of the run.
                        if (err_count_q == 8'd0) begin
                            first_err_d = ret_addr_q;
                        end
                    end
                    if (ret_addr_q == last_q) begin
                        state_d = S_FINISH;
                        pass_d  = (err_count_d == 8'd0);
                    end
                end
            end

            S_FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                gen_enable = 1'b1;
                chk_enable = 1'b1;
                gen_pause  = 1'b1;
                chk_pause  = 1'b1;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_lfsr_test_sequencer.sv
// Bench for lfsr_test_sequencer (ADDR_W = 9).
// The bench provides behavioural models of both LFSRs (polynomial 0x1D,
// shift left) and of a memory with configurable ack stalls, read latency,
// outstanding-read limit and data corruption. Expected write and read
// addresses and data are queued when a run starts and are popped as the
// DUT issues requests.

module tb_lfsr_test_sequencer;

    localparam int AW = 9;
    localparam logic [7:0] LFSR_PARAM_SEED = 8'hA5;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [7:0]    seed_in;
    logic [AW-1:0] last_addr;
    logic          gen_enable, gen_pause, gen_load;
    logic [7:0]    gen_ldata, gen_data;
    logic          chk_enable, chk_pause, chk_load;
    logic [7:0]    chk_ldata, chk_data;
    logic          mem_wr_req, mem_rd_req;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ack;
    logic          mem_rvalid;
    logic [7:0]    mem_rdata;
    logic          busy, done, pass;
    logic [7:0]    err_count;
    logic [AW-1:0] first_err_addr;

    lfsr_test_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .seed_in(seed_in),
        .last_addr(last_addr),
        .gen_enable(gen_enable), .gen_pause(gen_pause), .gen_load(gen_load),
        .gen_ldata(gen_ldata), .gen_data(gen_data),
        .chk_enable(chk_enable), .chk_pause(chk_pause), .chk_load(chk_load),
        .chk_ldata(chk_ldata), .chk_data(chk_data),
        .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
    endfunction

    // LFSR models
    logic [7:0] gen_lfsr = LFSR_PARAM_SEED;
    logic [7:0] chk_lfsr = LFSR_PARAM_SEED;
    assign gen_data = gen_lfsr;
    assign chk_data = chk_lfsr;

    always @(posedge clk) begin
        if (!gen_enable)    gen_lfsr <= LFSR_PARAM_SEED;
        else if (gen_load)  gen_lfsr <= gen_ldata;
        else if (!gen_pause) gen_lfsr <= lfsr_next(gen_lfsr);
        if (!chk_enable)    chk_lfsr <= LFSR_PARAM_SEED;
        else if (chk_load)  chk_lfsr <= chk_ldata;
        else if (!chk_pause) chk_lfsr <= lfsr_next(chk_lfsr);
    end

    typedef struct {
        logic [7:0] seed;
        int         last;
        int         lat;
        int         max_out;
        bit         stall;
        int         corrupt;
        bit         corrupt_all;
        bit         poke_start;
        bit         spur;
        bit         exp_pass;
        int         exp_err;
        int         exp_first;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wexp_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } ret_t;

    wexp_t      wq[$];
    int         rdq[$];
    ret_t       rq[$];
    logic [7:0] mem [512];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int cur_lat, cur_max_out, cur_corrupt;
    bit cur_corrupt_all, cur_stall, cur_spur;
    int stall_cnt, writes_seen, overlap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({gen_enable, gen_pause, gen_load, gen_ldata,
                    chk_enable, chk_pause, chk_load, chk_ldata,
                    mem_wr_req, mem_rd_req, mem_addr, mem_wdata,
                    busy, done, pass, err_count, first_err_addr});
    endfunction

    // One clock cycle of the memory model, executed at the falling edge.
    task automatic tick();
        wexp_t e;
        ret_t  r;
        int    ea;
        @(negedge clk);
        cyc++;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rq[0].data;
            void'(rq.pop_front());
        end else if (cur_spur && wq.size() > 0) begin
            // Garbage return while no read is outstanding (DUT not in READ).
            mem_rvalid = 1'b1;
            mem_rdata  = 8'h00;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 8'h00;
        end
        mem_ack = 1'b1;
        if (cur_stall && writes_seen == 2 && stall_cnt < 3 && mem_wr_req && wq.size() > 0) begin
            mem_ack = 1'b0;
            stall_cnt++;
            check("stall_addr", 64'(mem_addr), 64'(wq[0].addr));
            check("stall_wdata", 64'(mem_wdata), 64'(wq[0].data));
        end
        if (mem_rd_req && rq.size() >= cur_max_out) mem_ack = 1'b0;
        #1;
        if (mem_wr_req && mem_rd_req) overlap++;
        if (mem_wr_req && mem_ack) begin
            check("wr_expected", 64'(wq.size() > 0), 64'(1));
            if (wq.size() > 0) begin
                e = wq.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
            end
            mem[mem_addr] = (cur_corrupt_all || int'(mem_addr) == cur_corrupt) ? 8'h00 : mem_wdata;
            writes_seen++;
        end
        if (mem_rd_req && mem_ack) begin
            check("rd_expected", 64'(rdq.size() > 0), 64'(1));
            if (rdq.size() > 0) begin
                ea = rdq.pop_front();
                check("rd_addr", 64'(mem_addr), 64'(ea));
            end
            r.data = mem[mem_addr];
            r.due  = cyc + cur_lat;
            rq.push_back(r);
        end
    endtask

    task automatic prime(input vec_t v);
        logic [7:0] d;
        wexp_t      e;
        cur_lat         = v.lat;
        cur_max_out     = v.max_out;
        cur_corrupt     = v.corrupt;
        cur_corrupt_all = v.corrupt_all;
        cur_stall       = v.stall;
        cur_spur        = v.spur;
        stall_cnt       = 0;
        writes_seen     = 0;
        overlap         = 0;
        wq.delete();
        rdq.delete();
        rq.delete();
        d = v.seed;
        for (int a = 0; a <= v.last; a++) begin
            e.addr = AW'(a);
            e.data = d;
            wq.push_back(e);
            rdq.push_back(a);
            d = lfsr_next(d);
        end
    endtask

    task automatic pulse_start(input vec_t v);
        seed_in   = v.seed;
        last_addr = AW'(v.last);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        // Changing the inputs afterwards checks they were latched at start.
        seed_in   = ~v.seed;
        last_addr = ~AW'(v.last);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int budget;
        bit got;
        prime(v);
        pulse_start(v);
        budget = (v.last + 1) * (v.lat + 2) * 2 + 40;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            start = v.poke_start && (i == 4);
            tick();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({name, "_done_seen"}, 64'(got), 64'(1));
        if (got) begin
            check({name, "_pass"}, 64'(pass), 64'(v.exp_pass));
            check({name, "_err_count"}, 64'(err_count), 64'(v.exp_err));
            check({name, "_first_err"}, 64'(first_err_addr), 64'(v.exp_first));
        end
        tick();
        check({name, "_done_busy_after"}, 64'({done, busy}), 64'(0));
        check({name, "_status_hold"}, 64'({pass, err_count, first_err_addr}),
              64'({v.exp_pass, 8'(v.exp_err), AW'(v.exp_first)}));
        check({name, "_writes_left"}, 64'(wq.size()), 64'(0));
        check({name, "_reads_left"}, 64'(rdq.size()), 64'(0));
        check({name, "_returns_left"}, 64'(rq.size()), 64'(0));
        check({name, "_wr_rd_overlap"}, 64'(overlap), 64'(0));
    endtask

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vr, vc;
        int   done_cnt;
        bit   reached;

        //            seed   last lat max stall corrupt all  poke spur pass err first
        vecs[0] = '{8'h20,   3,  1,  4, 1'b0,  -1, 1'b0, 1'b0, 1'b0, 1'b1,   0, 0};
        vecs[1] = '{8'h20,   3,  1,  4, 1'b0,   2, 1'b0, 1'b0, 1'b0, 1'b0,   1, 2};
        vecs[2] = '{8'h20,   3,  1,  4, 1'b1,  -1, 1'b0, 1'b0, 1'b0, 1'b1,   0, 0};
        vecs[3] = '{8'h5A,   7,  4,  3, 1'b0,  -1, 1'b0, 1'b1, 1'b0, 1'b1,   0, 0};
        vecs[4] = '{8'h01,   0,  1,  4, 1'b0,  -1, 1'b0, 1'b0, 1'b0, 1'b1,   0, 0};
        vecs[5] = '{8'hC3, 299,  2,  4, 1'b0,  -1, 1'b1, 1'b0, 1'b0, 1'b0, 255, 0};
        vecs[6] = '{8'h77, 511,  1,  4, 1'b0,  -1, 1'b0, 1'b0, 1'b0, 1'b1,   0, 0};
        vecs[7] = '{8'h20,   3,  3,  2, 1'b0,   3, 1'b0, 1'b0, 1'b1, 1'b0,   1, 3};

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        cur_lat = 1; cur_max_out = 4; cur_corrupt = -1;
        cur_corrupt_all = 1'b0; cur_stall = 1'b0; cur_spur = 1'b0;
        stall_cnt = 0; writes_seen = 0; overlap = 0;

        reset_n    = 1'b0;
        start      = 1'b0;
        seed_in    = 8'h00;
        last_addr  = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        #1;
        check("reset_outputs", all_outputs(), 64'(0));
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_outputs", all_outputs(), 64'(0));

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of READ, with errors already counted.
        vr = '{8'h33, 20, 2, 4, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        prime(vr);
        pulse_start(vr);
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (err_count >= 8'd3) begin
                reached = 1'b1;
                break;
            end
        end
        check("pre_reset_in_read", 64'(reached), 64'(1));
        check("pre_reset_busy", 64'(busy), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("midrun_reset_outputs", all_outputs(), 64'(0));
        wq.delete();
        rdq.delete();
        rq.delete();
        cur_corrupt_all = 1'b0;
        tick();
        reset_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("no_done_after_reset", 64'(done_cnt), 64'(0));

        vc = '{8'h9C, 15, 2, 4, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
        run_vec("after_reset", vc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lfsr_test_sequencer.md
LFSR_TEST_SEQUENCER -- requirements
Module: lfsr_test_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: width of the memory word address and of the word counters.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 Port start, input, 1: begins a test run; sampled in IDLE only.
REQ-005 Port seed_in, input, 8: initial pattern value for the run.
REQ-006 Port last_addr, input, ADDR_W: final word address tested, inclusive; sampled at start.
REQ-007 Ports gen_enable, gen_pause, gen_load, output, 1 each; port gen_ldata, output, 8: control of the write-pattern LFSR.
REQ-008 Port gen_data, input, 8: current value of the write-pattern LFSR.
REQ-009 Ports chk_enable, chk_pause, chk_load, output, 1 each; port chk_ldata, output, 8: control of the check-pattern LFSR.
REQ-010 Port chk_data, input, 8: current value of the check-pattern LFSR.
REQ-011 Ports mem_wr_req, mem_rd_req, output, 1 each; port mem_addr, output, ADDR_W; port mem_wdata, output, 8: memory request.
REQ-012 Port mem_ack, input, 1: the memory accepts the current request in this cycle.
REQ-013 Ports mem_rvalid, input, 1, and mem_rdata, input, 8: read return; returns arrive in request order.
REQ-014 Ports busy, done, pass, output, 1 each; port err_count, output, 8; port first_err_addr, output, ADDR_W: status.

Function
REQ-015 LFSR semantics: an LFSR with enable=0 holds its seed parameter; with load=1 it takes ldata; otherwise it advances one step per cycle when pause=0.
REQ-016 States: IDLE, LOAD, WRITE, READ, FINISH; state and all counters are registered.
REQ-017 IDLE: gen_enable and chk_enable = 0, all memory requests = 0, busy = 0; start=1 -> LOAD, latch seed_in and last_addr, clear err_count, first_err_addr and pass.
REQ-018 LOAD (1 cycle): gen_enable = chk_enable = 1, gen_load = chk_load = 1, gen_ldata = chk_ldata = latched seed; wr_addr = 0 -> WRITE.
REQ-019 WRITE: mem_wr_req = 1, mem_addr = wr_addr, mem_wdata = gen_data; gen_pause = !mem_ack (combinational); on mem_ack wr_addr increments.
REQ-020 WRITE: on mem_ack with wr_addr == last_addr -> READ, with rd_addr = 0 and ret_addr = 0.
REQ-021 READ: mem_rd_req = 1 while rd_addr has not yet issued last_addr; mem_addr = rd_addr; on mem_ack rd_addr increments; multiple reads may be outstanding.
REQ-022 READ: chk_pause = !mem_rvalid; on mem_rvalid, compare mem_rdata with chk_data and increment ret_addr.
REQ-023 Mismatch: err_count increments, saturating at 255; on the first mismatch of the run, first_err_addr = ret_addr.
REQ-024 READ: mem_rvalid with ret_addr == last_addr -> FINISH; the final compare is included in the count.
REQ-025 FINISH (1 cycle): done = 1 and pass = (err_count == 0 after the final compare) -> IDLE; pass, err_count and first_err_addr hold until the next start.
REQ-026 busy = 1 in LOAD, WRITE, READ and FINISH.
REQ-027 gen_load, chk_load and the requests are 0 outside the states named above; pause is 1 wherever the respective enable is 1 and no advance is specified.
REQ-028 start while busy is ignored; mem_rvalid outside READ is ignored.
REQ-029 last_addr = 0 tests exactly one word; last_addr = all-ones tests 2^ADDR_W words, and the counters wrap without error.
REQ-030 mem_wr_req and mem_rd_req are never asserted in the same cycle.

Reset
REQ-031 reset_n low (asynchronous, any state, including mid-run) -> IDLE.
REQ-032 Reset values: all outputs 0, except gen_ldata and chk_ldata = 0; err_count = 0 and first_err_addr = 0.
REQ-033 An interrupted run is discarded; no done pulse is generated.

Verification
REQ-034 Scenario: seed_in=0x20, last_addr=3, mem_ack tied high, ideal memory -> writes 0x20, 0x40, 0x80, 0x1D to addresses 0-3; done=1, pass=1, err_count=0.
REQ-035 Scenario: as REQ-034, but the memory corrupts address 2 to 0x00 -> err_count=1, first_err_addr=2, pass=0.
REQ-036 Scenario: mem_ack low for 3 cycles mid-write -> mem_wdata and mem_addr stay stable; the write sequence is unchanged.
REQ-037 Scenario: read returns delayed 4 cycles with 3 reads outstanding -> checks are in order and pass=1.
REQ-038 Scenario: reset_n pulsed low during READ -> all outputs 0 immediately, no done pulse; a new start runs cleanly.
REQ-039 Scenario: every word corrupted, last_addr=299 with ADDR_W=9 -> err_count saturates at 255 and first_err_addr=0.
